// File: rtl/fx3_pkg.sv
// Shared constants and types for the FX3 slave-FIFO responder model.
package fx3_pkg;

   localparam int         FX3_DATA_W  = 32;
   localparam logic [1:0] FX3_ADDR_RD = 2'b11;
   localparam logic [1:0] FX3_ADDR_WR = 2'b00;

   // Bus events decoded from the master strobes on one edge.
   typedef struct packed {
      logic rd;
      logic wr;
      logic pk;
   } fx3_ev_t;

endpackage

// File: rtl/fx3_slave_fifo_model_if.sv
// FX3 slave-FIFO bus as seen between the FPGA master and the FX3 side.
interface fx3_slave_fifo_model_if
   import fx3_pkg::*;
#(
   parameter int DATA_W = FX3_DATA_W
) ();

   logic              SLCS;
   logic              SLRD;
   logic              SLWR;
   logic              SLOE;
   logic              PKEND;
   logic [1:0]        ADDR;
   logic [DATA_W-1:0] dq_in;
   logic [DATA_W-1:0] dq_out;
   logic              dq_oe;
   logic              FLAGA;
   logic              FLAGB;
   logic              FLAGC;
   logic              FLAGD;

   modport master (
      output SLCS, SLRD, SLWR, SLOE, PKEND, ADDR, dq_in,
      input  dq_out, dq_oe, FLAGA, FLAGB, FLAGC, FLAGD
   );

   modport slave (
      input  SLCS, SLRD, SLWR, SLOE, PKEND, ADDR, dq_in,
      output dq_out, dq_oe, FLAGA, FLAGB, FLAGC, FLAGD
   );

endinterface

// File: rtl/fx3_sfifo_buf.sv
// Synchronous FIFO with occupancy count. The read port is either show-ahead
// (head word combinational) or registered (word captured on the popping edge).
module fx3_sfifo_buf #(
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 32,
   parameter bit SHOW_AHEAD = 1'b0
) (
   input  logic                   clk_pll,
   input  logic                   reset_,
   input  logic                   push,
   input  logic [DATA_W-1:0]      push_data,
   input  logic                   pop,
   output logic [DATA_W-1:0]      rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  cnt;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign count   = cnt;

   // Storage write.
   // NOTE: the array has no reset; the count alone defines which words are valid.
   always_ff @(posedge clk_pll) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy update; a same-edge push and pop leave the count unchanged.
   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_pll or negedge reset_) begin
      if (!reset_) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   if (SHOW_AHEAD) begin : g_show
      assign rd_data = mem[rd_ptr];
   end else begin : g_reg
      logic [DATA_W-1:0] rd_q;

      // Capture the popped word; it is held while no pop occurs.
      always_ff @(posedge clk_pll or negedge reset_) begin
         if (!reset_)     rd_q <= '0;
         else if (pop_ok) rd_q <= mem[rd_ptr];
      end

      assign rd_data = rd_q;
   end

endmodule

// File: rtl/fx3_slave_fifo_model.sv
// FX3 side of the synchronous slave-FIFO bus: a host-filled read socket, a
// master-filled write socket, registered flags and a two-stage read path.
module fx3_slave_fifo_model
   import fx3_pkg::*;
#(
   parameter int DATA_W = FX3_DATA_W,
   parameter int DEPTH  = 32,
   parameter int WMARK  = 4
) (
   input  logic                  clk_pll,
   input  logic                  reset_,
   fx3_slave_fifo_model_if.slave bus,
   input  logic                  h_wr_valid,
   output logic                  h_wr_ready,
   input  logic [DATA_W-1:0]     h_wr_data,
   output logic                  h_rd_valid,
   input  logic                  h_rd_ready,
   output logic [DATA_W-1:0]     h_rd_data,
   output logic [15:0]           pkend_cnt,
   output logic                  err_underrun,
   output logic                  err_overrun
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fx3_ev_t           ev;
   logic [CNT_W-1:0]  rs_cnt, ws_cnt;
   logic              rs_full, rs_empty, ws_full, ws_empty;
   logic              rs_push, rs_pop, ws_push, ws_pop;
   logic [DATA_W-1:0] rs_data;
   logic [CNT_W-1:0]  rs_free, ws_free;
   logic [DATA_W-1:0] dq_q;
   logic              oe_q;
   logic              flag_a, flag_b, flag_c, flag_d;
   logic              alive;

   // Decode the master strobes into read, write and packet-end events.
   always_comb begin
      ev    = '0;
      ev.rd = !bus.SLCS && !bus.SLRD && (bus.ADDR == FX3_ADDR_RD);
      ev.wr = !bus.SLCS && !bus.SLWR && (bus.ADDR == FX3_ADDR_WR);
      ev.pk = !bus.SLCS && !bus.PKEND && bus.SLWR;
   end

   // An empty-socket pop is never paired with a same-edge push: it is an underrun.
   assign rs_pop     = ev.rd && !rs_empty;
   assign rs_push    = h_wr_valid && h_wr_ready;
   assign ws_push    = ev.wr && !ws_full;
   assign ws_pop     = h_rd_valid && h_rd_ready;
   assign h_wr_ready = alive && !rs_full;
   assign h_rd_valid = !ws_empty;
   assign rs_free    = CNT_W'(DEPTH) - rs_cnt;
   assign ws_free    = CNT_W'(DEPTH) - ws_cnt;

   fx3_sfifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SHOW_AHEAD(1'b0)) u_rd_sock (
      .clk_pll   (clk_pll),
      .reset_    (reset_),
      .push      (rs_push),
      .push_data (h_wr_data),
      .pop       (rs_pop),
      .rd_data   (rs_data),
      .count     (rs_cnt),
      .full      (rs_full),
      .empty     (rs_empty)
   );

   fx3_sfifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SHOW_AHEAD(1'b1)) u_wr_sock (
      .clk_pll   (clk_pll),
      .reset_    (reset_),
      .push      (ws_push),
      .push_data (bus.dq_in),
      .pop       (ws_pop),
      .rd_data   (h_rd_data),
      .count     (ws_cnt),
      .full      (ws_full),
      .empty     (ws_empty)
   );

   // Second read stage and output enable; an underrun re-presents the held word.
   always_ff @(posedge clk_pll or negedge reset_) begin
      if (!reset_) begin
         dq_q <= '0;
         oe_q <= 1'b0;
      end else begin
         dq_q <= rs_data;
         oe_q <= !bus.SLCS && !bus.SLOE && (bus.ADDR == FX3_ADDR_RD);
      end
   end

   // Flags follow the settled occupancy one edge later; alive gates host ready out of reset.
   always_ff @(posedge clk_pll or negedge reset_) begin
      if (!reset_) begin
         flag_a <= 1'b0;
         flag_b <= 1'b0;
         flag_c <= 1'b0;
         flag_d <= 1'b0;
         alive  <= 1'b0;
      end else begin
         flag_a <= (ws_free != '0);
         flag_b <= (ws_free > CNT_W'(WMARK));
         flag_c <= (rs_cnt != '0);
         flag_d <= (rs_cnt > CNT_W'(WMARK));
         alive  <= 1'b1;
      end
   end

   // Saturating packet-end counter and sticky error flags.
   always_ff @(posedge clk_pll or negedge reset_) begin
      if (!reset_) begin
         pkend_cnt    <= '0;
         err_underrun <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         if (ev.pk && (pkend_cnt != 16'hFFFF)) pkend_cnt <= pkend_cnt + 16'd1;
         if (ev.rd && rs_empty)                err_underrun <= 1'b1;
         if (ev.wr && ws_full)                 err_overrun  <= 1'b1;
      end
   end

   assign bus.dq_out = dq_q;
   assign bus.dq_oe  = oe_q;
   assign bus.FLAGA  = flag_a;
   assign bus.FLAGB  = flag_b;
   assign bus.FLAGC  = flag_c;
   assign bus.FLAGD  = flag_d;

endmodule

// File: tb/tb_fx3_slave_fifo_model.sv
// Directed bench for the FX3 slave-FIFO responder model.
module tb_fx3_slave_fifo_model;
   import fx3_pkg::*;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int WMARK  = 4;

   logic              clk_pll = 1'b0;
   logic              reset_  = 1'b0;
   logic              h_wr_valid;
   logic              h_wr_ready;
   logic [DATA_W-1:0] h_wr_data;
   logic              h_rd_valid;
   logic              h_rd_ready;
   logic [DATA_W-1:0] h_rd_data;
   logic [15:0]       pkend_cnt;
   logic              err_underrun;
   logic              err_overrun;

   int n_tests = 0;
   int n_fail  = 0;

   fx3_slave_fifo_model_if #(.DATA_W(DATA_W)) bus ();

   fx3_slave_fifo_model #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WMARK(WMARK)) dut (
      .clk_pll      (clk_pll),
      .reset_       (reset_),
      .bus          (bus),
      .h_wr_valid   (h_wr_valid),
      .h_wr_ready   (h_wr_ready),
      .h_wr_data    (h_wr_data),
      .h_rd_valid   (h_rd_valid),
      .h_rd_ready   (h_rd_ready),
      .h_rd_data    (h_rd_data),
      .pkend_cnt    (pkend_cnt),
      .err_underrun (err_underrun),
      .err_overrun  (err_overrun)
   );

   always #5 clk_pll = ~clk_pll;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One rising edge, then return on the falling edge where inputs change and outputs are sampled.
   task automatic step();
      @(posedge clk_pll);
      @(negedge clk_pll);
   endtask

   task automatic bus_idle();
      bus.SLCS  = 1'b1;
      bus.SLRD  = 1'b1;
      bus.SLWR  = 1'b1;
      bus.SLOE  = 1'b1;
      bus.PKEND = 1'b1;
      bus.ADDR  = 2'b01;
      bus.dq_in = '0;
   endtask

   task automatic host_push(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         h_wr_valid = 1'b1;
         h_wr_data  = base + 32'(i);
         step();
      end
      h_wr_valid = 1'b0;
   endtask

   initial begin
      bus_idle();
      h_wr_valid = 1'b0;
      h_wr_data  = '0;
      h_rd_ready = 1'b0;

      // Reset state
      step();
      step();
      check("rst_flaga", 32'(bus.FLAGA), 32'd0);
      check("rst_flagc", 32'(bus.FLAGC), 32'd0);
      check("rst_dq_oe", 32'(bus.dq_oe), 32'd0);
      check("rst_dq_out", bus.dq_out, 32'd0);
      check("rst_h_wr_ready", 32'(h_wr_ready), 32'd0);
      check("rst_h_rd_valid", 32'(h_rd_valid), 32'd0);
      check("rst_pkend", 32'(pkend_cnt), 32'd0);
      reset_ = 1'b1;
      step();
      check("rel_flaga", 32'(bus.FLAGA), 32'd1);
      check("rel_flagb", 32'(bus.FLAGB), 32'd1);
      check("rel_flagc", 32'(bus.FLAGC), 32'd0);
      check("rel_h_wr_ready", 32'(h_wr_ready), 32'd1);

      // 1: 16-word burst read, two-cycle latency, FLAGD/FLAGC falling edges
      host_push(32'h100, 16);
      step();
      step();
      check("t1_flagc_pre", 32'(bus.FLAGC), 32'd1);
      check("t1_flagd_pre", 32'(bus.FLAGD), 32'd1);
      bus.SLCS = 1'b0;
      bus.SLRD = 1'b0;
      bus.SLOE = 1'b0;
      bus.ADDR = FX3_ADDR_RD;
      for (int j = 0; j < 18; j++) begin
         step();
         if (j == 15) bus.SLRD = 1'b1;
         if (j == 0) check("t1_dq_oe", 32'(bus.dq_oe), 32'd1);
         if (j >= 1 && j <= 16) check("t1_dq_out", bus.dq_out, 32'h100 + 32'(j - 1));
         check("t1_flagd", 32'((16 - j) > WMARK), 32'(bus.FLAGD) ^ 32'd0);
         check("t1_flagc", 32'(bus.FLAGC), 32'((16 - j) > 0));
      end
      bus_idle();
      step();
      check("t1_dq_oe_off", 32'(bus.dq_oe), 32'd0);
      check("t1_no_underrun", 32'(err_underrun), 32'd0);

      // 2: fill write socket, overrun drop, host drains in order
      check("t2_flaga_pre", 32'(bus.FLAGA), 32'd1);
      bus.SLCS = 1'b0;
      bus.SLWR = 1'b0;
      bus.ADDR = FX3_ADDR_WR;
      for (int i = 0; i < 32; i++) begin
         bus.dq_in = 32'hA0 + 32'(i);
         step();
      end
      check("t2_flaga_e32", 32'(bus.FLAGA), 32'd1);
      check("t2_ovr_e32", 32'(err_overrun), 32'd0);
      bus.dq_in = 32'hEE;
      step();
      check("t2_flaga_e33", 32'(bus.FLAGA), 32'd0);
      check("t2_flagb_e33", 32'(bus.FLAGB), 32'd0);
      check("t2_ovr_e33", 32'(err_overrun), 32'd1);
      bus_idle();
      h_rd_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         check("t2_h_rd_valid", 32'(h_rd_valid), 32'd1);
         check("t2_h_rd_data", h_rd_data, 32'hA0 + 32'(i));
         step();
      end
      h_rd_ready = 1'b0;
      check("t2_drained", 32'(h_rd_valid), 32'd0);

      // 3: read on an empty read socket
      bus.SLCS = 1'b0;
      bus.SLRD = 1'b0;
      bus.ADDR = FX3_ADDR_RD;
      step();
      bus_idle();
      check("t3_underrun", 32'(err_underrun), 32'd1);
      check("t3_flagc", 32'(bus.FLAGC), 32'd0);
      step();
      check("t3_flagc_late", 32'(bus.FLAGC), 32'd0);
      check("t3_dq_hold", bus.dq_out, 32'h10F);

      // 4: simultaneous host push and master pop at occupancy 5
      host_push(32'h200, 5);
      step();
      step();
      check("t4_flagd_pre", 32'(bus.FLAGD), 32'd1);
      bus.SLCS   = 1'b0;
      bus.SLRD   = 1'b0;
      bus.ADDR   = FX3_ADDR_RD;
      h_wr_valid = 1'b1;
      h_wr_data  = 32'h205;
      for (int j = 0; j < 8; j++) begin
         step();
         if (j == 0) h_wr_data = 32'h206;
         if (j == 1) h_wr_valid = 1'b0;
         if (j == 6) bus.SLRD = 1'b1;
         if (j >= 1) check("t4_dq_out", bus.dq_out, 32'h200 + 32'(j - 1));
         if (j <= 3) check("t4_flagd", 32'(bus.FLAGD), (j <= 2) ? 32'd1 : 32'd0);
      end
      bus_idle();
      step();
      check("t4_flagc_empty", 32'(bus.FLAGC), 32'd0);

      // 5: packet end commits, then combined PKEND+SLWR pushes one word
      bus.SLCS  = 1'b0;
      bus.PKEND = 1'b0;
      bus.ADDR  = FX3_ADDR_WR;
      step();
      step();
      step();
      bus.SLWR  = 1'b0;
      bus.dq_in = 32'h555;
      step();
      bus_idle();
      check("t5_pkend_cnt", 32'(pkend_cnt), 32'd3);
      check("t5_h_rd_valid", 32'(h_rd_valid), 32'd1);
      check("t5_h_rd_data", h_rd_data, 32'h555);
      h_rd_ready = 1'b1;
      step();
      h_rd_ready = 1'b0;
      check("t5_one_word", 32'(h_rd_valid), 32'd0);

      // 6: reset asserted mid-read with 10 words queued
      host_push(32'h300, 10);
      step();
      step();
      check("t6_flagd_pre", 32'(bus.FLAGD), 32'd1);
      bus.SLCS = 1'b0;
      bus.SLRD = 1'b0;
      bus.SLOE = 1'b0;
      bus.ADDR = FX3_ADDR_RD;
      step();
      step();
      step();
      check("t6_dq_mid", bus.dq_out, 32'h301);
      #1;
      reset_ = 1'b0;
      #1;
      check("t6_flaga", 32'(bus.FLAGA), 32'd0);
      check("t6_flagb", 32'(bus.FLAGB), 32'd0);
      check("t6_flagc", 32'(bus.FLAGC), 32'd0);
      check("t6_flagd", 32'(bus.FLAGD), 32'd0);
      check("t6_dq_oe", 32'(bus.dq_oe), 32'd0);
      check("t6_dq_out", bus.dq_out, 32'd0);
      check("t6_pkend", 32'(pkend_cnt), 32'd0);
      check("t6_err_u", 32'(err_underrun), 32'd0);
      check("t6_err_o", 32'(err_overrun), 32'd0);
      check("t6_h_wr_ready", 32'(h_wr_ready), 32'd0);
      bus_idle();
      @(negedge clk_pll);
      reset_ = 1'b1;
      step();
      check("t6_rel_flagc", 32'(bus.FLAGC), 32'd0);
      check("t6_rel_flaga", 32'(bus.FLAGA), 32'd1);
      check("t6_rel_flagb", 32'(bus.FLAGB), 32'd1);
      check("t6_rel_h_wr_ready", 32'(h_wr_ready), 32'd1);
      check("t6_rel_dq_out", bus.dq_out, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
